// File: rtl/approx_err_pkg.sv
// Shared types and width helpers for the approximate-multiplier error monitor.
// Contents: FSM state enum and width functions for product, sum and count buses.
// Width helpers take the operand width W; every result width derives from it.
package approx_err_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Product of two W-bit operands.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // Error sum: 2^(2W) pairs, each error below 2^(2W), so 4W bits cannot overflow.
  function automatic int sum_w(input int w);
    return 4 * w;
  endfunction

  // Pair counters must reach 2^(2W) inclusive.
  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

  // Drain counter width: MUL_LAT tops out at 8.
  localparam int DRAIN_CNT_W = 4;

endpackage

// File: rtl/approx_err_monitor_if.sv
// Operand/product bus between the error monitor and the multiplier under test.
// master: drives op_a/op_b, receives approx_p. slave: the multiplier side.
// No handshake: the multiplier returns a product a fixed latency after operands.
interface approx_err_monitor_if
  import approx_err_pkg::*;
#(
  parameter int W = 4
);

  logic [W-1:0]         op_a;
  logic [W-1:0]         op_b;
  logic [prod_w(W)-1:0] approx_p;

  modport master (output op_a, output op_b, input approx_p);
  modport slave  (input op_a, input op_b, output approx_p);

endinterface

// File: rtl/approx_err_pipe.sv
// Delay line carrying the exact product and a valid bit alongside the multiplier.
// Latency: MUL_LAT cycles (0 = combinational pass-through).
// Ports: in_vld/in_dat enter each cycle, out_vld/out_dat line up with approx_p.
module approx_err_pipe
  import approx_err_pkg::*;
#(
  parameter int W       = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic [prod_w(W)-1:0] in_dat,
  output logic                 out_vld,
  output logic [prod_w(W)-1:0] out_dat
);

  localparam int PW = prod_w(W);

  generate
    if (MUL_LAT == 0) begin : g_pass
      assign out_vld = in_vld;
      assign out_dat = in_dat;
    end else begin : g_dly
      logic [MUL_LAT-1:0] vld_q;
      logic [PW-1:0]      dat_q [MUL_LAT];

      // Only the valid bits need reset; data is qualified by them.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= in_vld;
          for (int i = 1; i < MUL_LAT; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        dat_q[0] <= in_dat;
        for (int i = 1; i < MUL_LAT; i++) dat_q[i] <= dat_q[i-1];
      end

      assign out_vld = vld_q[MUL_LAT-1];
      assign out_dat = dat_q[MUL_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/approx_err_monitor.sv
// Exhaustive error sweep of an external approximate W x W multiplier.
// Latency: done pulses 2^(2W)+MUL_LAT+1 cycles after the accepting start.
// Ports: start/busy/done control, mul bus to the multiplier, result registers.
// No backpressure: one operand pair per SWEEP cycle, start ignored while busy.
// Build option: define APPROX_ERR_MAX_EN to track err_max; otherwise it reads 0.
module approx_err_monitor
  import approx_err_pkg::*;
#(
  parameter int W       = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  approx_err_monitor_if.master  mul,
  output logic                  busy,
  output logic                  done,
  output logic [sum_w(W)-1:0]   err_sum,
  output logic [prod_w(W)-1:0]  err_max,
  output logic [cnt_w(W)-1:0]   cnt_over,
  output logic [cnt_w(W)-1:0]   cnt_under,
  output logic [cnt_w(W)-1:0]   cnt_exact
);

  localparam int PW = prod_w(W);
  localparam int SW = sum_w(W);
  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] IDX_ONE = PW'(1);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_ONE  = DRAIN_CNT_W'(1);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'((MUL_LAT > 0) ? MUL_LAT - 1 : 0);

  state_t                  state, state_nxt;
  logic [PW-1:0]           idx;
  logic [DRAIN_CNT_W-1:0]  drain_cnt;
  logic                    accept;
  logic [PW-1:0]           exact_cur;
  logic                    cmp_vld;
  logic [PW-1:0]           cmp_exact;
  logic                    is_over, is_under;
  logic [PW-1:0]           err_mag;

  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  // State register, sweep index and drain counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      done      <= (state_nxt == ST_DONE) && (state != ST_DONE);
      idx       <= (state == ST_SWEEP) ? idx + IDX_ONE : '0;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DRAIN_ONE : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    mul.op_a  = '0;
    mul.op_b  = '0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SWEEP;
      ST_SWEEP: begin
        busy     = 1'b1;
        mul.op_a = idx[PW-1:W];
        mul.op_b = idx[W-1:0];
        // With no multiplier latency the last compare happens this cycle.
        if (idx == '1) state_nxt = (MUL_LAT == 0) ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_nxt = ST_DONE;
      end
      ST_DONE:  if (start) state_nxt = ST_SWEEP;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign exact_cur = PW'(mul.op_a) * PW'(mul.op_b);

  approx_err_pipe #(
    .W       (W),
    .MUL_LAT (MUL_LAT)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (state == ST_SWEEP),
    .in_dat  (exact_cur),
    .out_vld (cmp_vld),
    .out_dat (cmp_exact)
  );

  always_comb begin
    is_over  = cmp_vld && (mul.approx_p > cmp_exact);
    is_under = cmp_vld && (mul.approx_p < cmp_exact);
    // Equal operands fall into the second arm and yield zero.
    err_mag  = is_over ? (mul.approx_p - cmp_exact) : (cmp_exact - mul.approx_p);
  end

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      err_sum   <= '0;
      cnt_over  <= '0;
      cnt_under <= '0;
      cnt_exact <= '0;
    end else if (cmp_vld) begin
      err_sum <= err_sum + SW'(err_mag);
      if (is_over)       cnt_over  <= cnt_over + CNT_ONE;
      else if (is_under) cnt_under <= cnt_under + CNT_ONE;
      else               cnt_exact <= cnt_exact + CNT_ONE;
    end
  end

`ifdef APPROX_ERR_MAX_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      err_max <= '0;
    end else if (cmp_vld && (err_mag > err_max)) begin
      err_max <= err_mag;
    end
  end
`else
  assign err_max = '0;
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// Scoreboard bench: two monitors (W=4/MUL_LAT=1 and W=2/MUL_LAT=0) driven by a
// behavioural multiplier with selectable error modes; expected results come
// from a whole-sweep reference model and are popped when done pulses.
module tb_approx_err_monitor;

  typedef struct {
    longint sum;
    longint mx;
    longint over;
    longint under;
    longint exact;
    longint done_cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   start4 = 1'b0;
  logic   start2 = 1'b0;
  longint cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;
  int     mode4 = 0;
  int     mode2 = 0;
  int     tbl [256];
  exp_t   q4 [$];
  exp_t   q2 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  approx_err_monitor_if #(.W(4)) bus4 ();
  approx_err_monitor_if #(.W(2)) bus2 ();

  logic        busy4, done4, busy2, done2;
  logic [15:0] sum4;
  logic [7:0]  max4;
  logic [8:0]  over4, under4, exact4;
  logic [7:0]  sum2;
  logic [3:0]  max2;
  logic [4:0]  over2, under2, exact2;

  approx_err_monitor #(.W(4), .MUL_LAT(1)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mul(bus4),
    .busy(busy4), .done(done4), .err_sum(sum4), .err_max(max4),
    .cnt_over(over4), .cnt_under(under4), .cnt_exact(exact4)
  );

  approx_err_monitor #(.W(2), .MUL_LAT(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mul(bus2),
    .busy(busy2), .done(done2), .err_sum(sum2), .err_max(max2),
    .cnt_over(over2), .cnt_under(under2), .cnt_exact(exact2)
  );

  // Multiplier behaviour: 0 exact, 1 exact+1, 2 LSB cleared, 3 random XOR noise.
  function automatic int approx_fn(input int w, input int mode, input int a, input int b);
    int e;
    int p;
    e = a * b;
    case (mode)
      1:       p = e + 1;
      2:       p = e & ~1;
      3:       p = e ^ tbl[(a << w) | b];
      default: p = e;
    endcase
    return p & ((1 << (2 * w)) - 1);
  endfunction

  // Multipliers under test: one registered stage for W=4, combinational for W=2.
  always @(posedge clk) bus4.approx_p <= 8'(approx_fn(4, mode4, int'(bus4.op_a), int'(bus4.op_b)));
  always_comb bus2.approx_p = 4'(approx_fn(2, mode2, int'(bus2.op_a), int'(bus2.op_b)));

  // Reference: walk every operand pair and tally errors directly.
  function automatic exp_t model(input int w, input int mode, input int lat, input longint c);
    exp_t r;
    int n, a, b, e, p, d;
    n = 1 << (2 * w);
    r = '{sum: 0, mx: 0, over: 0, under: 0, exact: 0, done_cyc: c + n + lat + 1};
    for (int k = 0; k < n; k++) begin
      a = k >> w;
      b = k & ((1 << w) - 1);
      e = a * b;
      p = approx_fn(w, mode, a, b);
      d = (p > e) ? p - e : e - p;
      if (p > e) r.over++;
      else if (p < e) r.under++;
      else r.exact++;
      r.sum += d;
`ifdef APPROX_ERR_MAX_EN
      if (d > r.mx) r.mx = d;
`endif
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input longint exp);
    n_vec++;
    if (act !== 64'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_tbl();
    for (int i = 0; i < 256; i++) tbl[i] = int'($urandom_range(0, 7));
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst && done4) begin
      if (q4.size() == 0) begin
        check("w4_unexpected_done", 64'(done4), 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("w4_err_sum", 64'(sum4), e.sum);
        check("w4_err_max", 64'(max4), e.mx);
        check("w4_cnt_over", 64'(over4), e.over);
        check("w4_cnt_under", 64'(under4), e.under);
        check("w4_cnt_exact", 64'(exact4), e.exact);
        check("w4_done_cycle", 64'(cyc), e.done_cyc);
        check("w4_busy_at_done", 64'(busy4), 0);
        check("w4_ops_idle", 64'({bus4.op_a, bus4.op_b}), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done2) begin
      if (q2.size() == 0) begin
        check("w2_unexpected_done", 64'(done2), 0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check("w2_err_sum", 64'(sum2), e.sum);
        check("w2_err_max", 64'(max2), e.mx);
        check("w2_cnt_over", 64'(over2), e.over);
        check("w2_cnt_under", 64'(under2), e.under);
        check("w2_cnt_exact", 64'(exact2), e.exact);
        check("w2_done_cycle", 64'(cyc), e.done_cyc);
        check("w2_ops_idle", 64'({bus2.op_a, bus2.op_b}), 0);
      end
    end
  end

  // One sweep on the selected DUT (4 or 2), optionally poking start mid-sweep.
  task automatic run(input int sel, input int mode, input bit poke);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    if (mode == 3) fill_tbl();
    if (sel == 4) begin
      mode4 = mode;
      q4.push_back(model(4, mode, 1, cyc));
      start4 = 1'b1;
    end else begin
      mode2 = mode;
      q2.push_back(model(2, mode, 0, cyc));
      start2 = 1'b1;
    end
    @(negedge clk);
    start4 = 1'b0;
    start2 = 1'b0;
    if (poke) begin
      repeat ($urandom_range(2, 10)) @(negedge clk);
      if (sel == 4) start4 = 1'b1; else start2 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      start2 = 1'b0;
    end
    for (int i = 0; i < 2000 && (q4.size() + q2.size()) != 0; i++) @(negedge clk);
    if ((q4.size() + q2.size()) != 0) begin
      check("done_timeout", 64'(q4.size() + q2.size()), 0);
      q4.delete();
      q2.delete();
    end
    // A second done pulse would surface in the monitor during these cycles.
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy4", 64'(busy4), 0);
    check("rst_done4", 64'(done4), 0);
    check("rst_sum4", 64'(sum4), 0);
    check("rst_cnt4", 64'({over4, under4, exact4}), 0);
    check("rst_ops4", 64'({bus4.op_a, bus4.op_b}), 0);
    rst = 1'b0;
    @(negedge clk);

    run(4, 0, 1'b0);
    run(4, 1, 1'b0);
    run(4, 2, 1'b0);
    run(4, 3, 1'b0);
    run(4, 3, 1'b1);
    run(4, 0, 1'b1);

    // Abort a sweep at index 100 (op_a=6, op_b=4); no done may follow.
    @(negedge clk);
    mode4 = 3;
    fill_tbl();
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 400 && {bus4.op_a, bus4.op_b} != 8'd100; i++) @(negedge clk);
    check("abort_reach_idx", 64'({bus4.op_a, bus4.op_b}), 100);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy4), 0);
    check("abort_sum", 64'(sum4), 0);
    check("abort_cnt", 64'({over4, under4, exact4}), 0);
    check("abort_max", 64'(max4), 0);
    repeat (300) @(negedge clk);
    run(4, 0, 1'b0);
    run(4, 3, 1'b0);

    run(2, 0, 1'b1);
    run(2, 1, 1'b0);
    run(2, 3, 1'b1);
    run(2, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/approx_err_monitor.md
APPROX_ERR_MONITOR -- requirements
Module: approx_err_monitor

Interface
REQ-001 SHALL have parameter W, default 4: operand width of the multiplier under test (2..8).
REQ-002 SHALL have parameter MUL_LAT, default 1: cycles from op_a/op_b driven to matching approx_p valid (0..8).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  begin exhaustive sweep; sampled only in IDLE/DONE.
REQ-006 SHALL have port op_a  output  W  operand A to external approximate multiplier.
REQ-007 SHALL have port op_b  output  W  operand B to external approximate multiplier.
REQ-008 SHALL have port approx_p  input  2W  approximate product returned by the multiplier.
REQ-009 SHALL have port busy  output  1  high in SWEEP and DRAIN.
REQ-010 SHALL have port done  output  1  one-cycle pulse on entry to DONE.
REQ-011 SHALL have port err_sum  output  4W  sum of |approx_p - exact| over all pairs.
REQ-012 SHALL have port err_max  output  2W  largest single |approx_p - exact|.
REQ-013 SHALL have ports cnt_over, cnt_under, cnt_exact  output  2W+1 each  pairs with approx >, <, = exact.

Function
REQ-014 SHALL implement FSM IDLE -> SWEEP (start) -> DRAIN (last index issued) -> DONE (MUL_LAT drain cycles elapsed) -> SWEEP (start) ; DONE holds otherwise.
REQ-015 SHALL sweep index k = 0 .. 2^(2W)-1, one per SWEEP cycle, op_a = k[2W-1:W], op_b = k[W-1:0].
REQ-016 SHALL carry exact = op_a*op_b (2W bits) plus a valid bit through an MUL_LAT-stage delay line aligned with approx_p; MUL_LAT=0 compares same cycle.
REQ-017 SHALL, for each valid compare, add error magnitude to err_sum, update err_max, increment exactly one of the three counters; zero exact products included.
REQ-018 SHALL clear all result registers on the cycle start is accepted; results stay stable from done until next accepted start.
REQ-019 SHALL assert done exactly 2^(2W)+MUL_LAT+1 cycles after the accepting start cycle.
REQ-020 SHALL ignore start while busy; op_a/op_b SHALL be 0 outside SWEEP.
REQ-021 SHALL guarantee cnt_over+cnt_under+cnt_exact = 2^(2W) at done; widths chosen so no overflow, no saturation logic.

Reset
REQ-022 SHALL on rst: state IDLE, index 0, delay-line valids 0, busy/done 0, all results 0, op_a/op_b 0.
REQ-023 SHALL abort a sweep on rst mid-operation with no partial results retained and no done pulse.

Configuration
REQ-024 SHALL compile err_max tracking only when APPROX_ERR_MAX_EN is defined; undefined: err_max tied to 0, comparator/register absent, other outputs unchanged.

Structure
REQ-025 SHALL place FSM state enum and width helper constants (product width 2W, sum width 4W, count width 2W+1) in shared package approx_err_pkg.
REQ-026 SHALL implement the exact-product/valid delay line as sub-module approx_err_pipe (parameters W, MUL_LAT).

Verification
REQ-027 SHALL cover W=4, MUL_LAT=1, approx = exact model -> err_sum 0, err_max 0, cnt_exact 256, cnt_over 0, cnt_under 0, done 258 cycles after start.
REQ-028 SHALL cover W=4, approx = exact+1 -> err_sum 256, err_max 1, cnt_over 256.
REQ-029 SHALL cover W=4, approx = exact with LSB cleared -> cnt_under 64, cnt_exact 192, err_sum 64, err_max 1.
REQ-030 SHALL cover rst asserted at sweep index 100, then new start -> no done until full new sweep, results as for clean run.
REQ-031 SHALL cover start pulsed while busy -> ignored, single done at normal cycle; W=2, MUL_LAT=0 exact model -> cnt_exact 16, done 17 cycles after start.
REQ-032 SHALL cover both APPROX_ERR_MAX_EN defined and undefined builds (err_max 0 when undefined).
